// File: rtl/pipeline_hazard_controller_if.sv
// Hazard controller port bundle: hazard inputs from ID/EX/MEM, enables to stage regs.
// Perf counter signals exist only when HAZARD_PERF_CNT_EN is defined.
interface pipeline_hazard_controller_if #(
    parameter int CNT_W = 16
);
    logic       idex_memread;
    logic [4:0] idex_rd;
    logic [4:0] ifid_rs1;
    logic [4:0] ifid_rs2;
    logic       ifid_use_rs2;
    logic       ex_branch_taken;
    logic       dmem_busy;
    logic       pc_write;
    logic       ifid_write;
    logic       idex_write;
    logic       exmem_write;
    logic       ifid_flush;
    logic       idex_bubble;
    logic       mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] memwait_cnt;
`endif

    modport master (
        input  idex_memread, idex_rd, ifid_rs1, ifid_rs2,
        input  ifid_use_rs2, ex_branch_taken, dmem_busy,
`ifdef HAZARD_PERF_CNT_EN
        output stall_cnt, flush_cnt, memwait_cnt,
`endif
        output pc_write, ifid_write, idex_write, exmem_write,
        output ifid_flush, idex_bubble, mem_timeout
    );

    modport slave (
        output idex_memread, idex_rd, ifid_rs1, ifid_rs2,
        output ifid_use_rs2, ex_branch_taken, dmem_busy,
`ifdef HAZARD_PERF_CNT_EN
        input  stall_cnt, flush_cnt, memwait_cnt,
`endif
        input  pc_write, ifid_write, idex_write, exmem_write,
        input  ifid_flush, idex_bubble, mem_timeout
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline with memory-wait watchdog.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_controller #(
    parameter int MAX_MEM_WAIT = 16,
    parameter int CNT_W        = 16
) (
    input logic                          clk,
    input logic                          rst_n,
    pipeline_hazard_controller_if.master hz
);
    localparam int WW = $clog2(MAX_MEM_WAIT + 1);
    localparam logic [WW-1:0] WMAX = WW'(MAX_MEM_WAIT);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic          timeout_q, timeout_d;

    logic load_use;
    logic sel_freeze, sel_flush, sel_stall;
    logic pc_w, ifid_w, idex_w, exmem_w, flush, bubble;

    // The load sits in EX/MEM during LOAD_STALL, so it can never hazard twice.
    assign load_use = hz.idex_memread && (hz.idex_rd != 5'd0)
                   && ((hz.idex_rd == hz.ifid_rs1)
                    || (hz.ifid_use_rs2 && (hz.idex_rd == hz.ifid_rs2)))
                   && (state_q != LOAD_STALL);

    assign sel_freeze = hz.dmem_busy;
    assign sel_flush  = !hz.dmem_busy && hz.ex_branch_taken;
    assign sel_stall  = !hz.dmem_busy && !hz.ex_branch_taken && load_use;

    always_comb begin
        state_d    = RUN;
        wait_cnt_d = '0;
        timeout_d  = timeout_q;
        pc_w       = 1'b1;
        ifid_w     = 1'b1;
        idex_w     = 1'b1;
        exmem_w    = 1'b1;
        flush      = 1'b0;
        bubble     = 1'b0;
        unique case (1'b1)
            sel_freeze: begin
                pc_w    = 1'b0;
                ifid_w  = 1'b0;
                idex_w  = 1'b0;
                exmem_w = 1'b0;
                state_d = MEM_WAIT;
                if (wait_cnt_q == WMAX) begin
                    wait_cnt_d = wait_cnt_q;
                    timeout_d  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            sel_flush: begin
                flush  = 1'b1;
                bubble = 1'b1;
            end
            sel_stall: begin
                pc_w    = 1'b0;
                ifid_w  = 1'b0;
                bubble  = 1'b1;
                state_d = LOAD_STALL;
            end
            default: ;
        endcase
        // Hold every stage register and inject NOPs while in reset.
        if (!rst_n) begin
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            idex_w  = 1'b0;
            exmem_w = 1'b0;
            flush   = 1'b1;
            bubble  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign hz.pc_write    = pc_w;
    assign hz.ifid_write  = ifid_w;
    assign hz.idex_write  = idex_w;
    assign hz.exmem_write = exmem_w;
    assign hz.ifid_flush  = flush;
    assign hz.idex_bubble = bubble;
    assign hz.mem_timeout = timeout_q && rst_n;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] memwait_cnt_q, memwait_cnt_d;

    always_comb begin
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        memwait_cnt_d = memwait_cnt_q;
        if (sel_stall && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (sel_flush && !(&flush_cnt_q))
            flush_cnt_d = flush_cnt_q + 1'b1;
        if (sel_freeze && !(&memwait_cnt_q))
            memwait_cnt_d = memwait_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            memwait_cnt_q <= '0;
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            memwait_cnt_q <= memwait_cnt_d;
        end
    end

    assign hz.stall_cnt   = stall_cnt_q;
    assign hz.flush_cnt   = flush_cnt_q;
    assign hz.memwait_cnt = memwait_cnt_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W == 0);
`endif
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed-vector scoreboard bench for pipeline_hazard_controller (MAX_MEM_WAIT=4).
module tb_pipeline_hazard_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    pipeline_hazard_controller_if #(.CNT_W(16)) hz ();

    pipeline_hazard_controller #(
        .MAX_MEM_WAIT(4),
        .CNT_W       (16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hz   (hz.master)
    );

    // {pc_w, ifid_w, idex_w, exmem_w, flush, bubble, timeout}
    localparam logic [6:0] E_RUN = 7'b1111_000;
    localparam logic [6:0] E_STL = 7'b0011_010;
    localparam logic [6:0] E_FLS = 7'b1111_110;
    localparam logic [6:0] E_FRZ = 7'b0000_000;
    localparam logic [6:0] E_RST = 7'b0000_110;
    localparam logic [6:0] E_TO  = 7'b0000_001;

    typedef struct {
        logic [6:0] exp;
        string      name;
    } sb_t;

    sb_t sbq[$];
    int  vectors = 0;
    int  miscompares = 0;

    task automatic vec(input logic rst, input logic mr,
                       input logic [4:0] rd, input logic [4:0] r1,
                       input logic [4:0] r2, input logic u2,
                       input logic br, input logic bz,
                       input logic [6:0] exp, input string nm);
        sb_t e;
        @(posedge clk);
        #1;
        rst_n              = rst;
        hz.idex_memread    = mr;
        hz.idex_rd         = rd;
        hz.ifid_rs1        = r1;
        hz.ifid_rs2        = r2;
        hz.ifid_use_rs2    = u2;
        hz.ex_branch_taken = br;
        hz.dmem_busy       = bz;
        e.exp  = exp;
        e.name = nm;
        sbq.push_back(e);
    endtask

    task automatic idle(input logic [6:0] exp, input string nm);
        vec(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, exp, nm);
    endtask

    always @(negedge clk) begin
        sb_t        e;
        logic [6:0] got;
        if (sbq.size() > 0) begin
            e   = sbq.pop_front();
            got = {hz.pc_write, hz.ifid_write, hz.idex_write,
                   hz.exmem_write, hz.ifid_flush, hz.idex_bubble,
                   hz.mem_timeout};
            vectors++;
            if (got !== e.exp) begin
                miscompares++;
                $display("FAIL %s: got %b expected %b", e.name, got, e.exp);
            end
        end
    end

    initial begin
        hz.idex_memread    = 1'b0;
        hz.idex_rd         = 5'd0;
        hz.ifid_rs1        = 5'd0;
        hz.ifid_rs2        = 5'd0;
        hz.ifid_use_rs2    = 1'b0;
        hz.ex_branch_taken = 1'b0;
        hz.dmem_busy       = 1'b0;
        #2 rst_n = 1'b0;

        vec(0, 0, 0, 0, 0, 0, 0, 0, E_RST, "reset_idle");
        vec(0, 1, 5, 5, 0, 0, 1, 1, E_RST, "reset_hazards");
        idle(E_RUN, "reset_release");

        vec(1, 1, 5, 5, 0, 0, 0, 0, E_STL, "load_use_rs1");
        idle(E_RUN, "after_stall");
        vec(1, 1, 0, 0, 0, 0, 0, 0, E_RUN, "rd_zero");

        vec(1, 1, 7, 3, 7, 0, 0, 0, E_RUN, "rs2_unused");
        vec(1, 1, 7, 3, 7, 1, 0, 0, E_STL, "rs2_used");
        idle(E_RUN, "after_rs2_stall");

        vec(1, 1, 9, 9, 0, 0, 0, 0, E_STL, "b2b_first");
        idle(E_RUN, "b2b_gap");
        vec(1, 1, 4, 2, 4, 1, 0, 0, E_STL, "b2b_second");
        idle(E_RUN, "b2b_done");

        vec(1, 1, 6, 6, 0, 0, 1, 0, E_FLS, "branch_over_ld");
        idle(E_RUN, "after_branch");

        vec(1, 0, 0, 0, 0, 0, 1, 1, E_FRZ, "busy_br_1");
        vec(1, 0, 0, 0, 0, 0, 1, 1, E_FRZ, "busy_br_2");
        vec(1, 0, 0, 0, 0, 0, 1, 1, E_FRZ, "busy_br_3");
        vec(1, 0, 0, 0, 0, 0, 1, 0, E_FLS, "busy_br_release");

        vec(1, 1, 8, 8, 0, 0, 0, 1, E_FRZ, "busy_ld_freeze");
        vec(1, 1, 8, 8, 0, 0, 0, 0, E_STL, "busy_ld_release");
        idle(E_RUN, "busy_ld_done");

        for (int i = 1; i <= 6; i++)
            vec(1, 0, 0, 0, 0, 0, 0, 1,
                (i == 6) ? (E_FRZ | E_TO) : E_FRZ,
                $sformatf("wd_busy_%0d", i));
        idle(E_RUN | E_TO, "wd_sticky_1");
        idle(E_RUN | E_TO, "wd_sticky_2");
        vec(1, 1, 3, 3, 0, 0, 0, 0, E_STL | E_TO, "wd_stall");
        vec(0, 0, 0, 0, 0, 0, 0, 0, E_RST, "wd_reset");
        idle(E_RUN, "wd_cleared");

        vec(1, 1, 5, 0, 5, 1, 0, 0, E_STL, "mid_stall");
        vec(0, 1, 5, 0, 5, 1, 0, 0, E_RST, "mid_stall_rst");
        vec(1, 1, 5, 5, 0, 0, 0, 0, E_STL, "post_rst_stall");
        vec(1, 0, 0, 0, 0, 0, 0, 1, E_FRZ, "mid_wait");
        vec(0, 0, 0, 0, 0, 0, 0, 1, E_RST, "mid_wait_rst");
        idle(E_RUN, "post_rst_run");

        @(posedge clk);
        for (int k = 0; k < 5 && sbq.size() > 0; k++)
            @(posedge clk);
        if (sbq.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
